data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the datapath's data-memory interface. It accepts one load or store request at a time through a valid/ready handshake and inserts a configurable number of wait states. Sub-doubleword stores are handled by merging byte lanes into the addressed doubleword. Loads return the addressed bytes right-justified and zero-filled; sign/zero extension stays in the load block. It replaces the fixed single-cycle data memory behind the ALU-result/B-register paths.

## Interface
Parameters:
- DEPTH, 256: number of 64-bit doublewords stored; power of two, at least 2.
- WAIT_CYCLES, 1: wait states between acceptance and access; 0 or more.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_wdata  in  64  store data, right-justified.
- rsp_valid  out  1  response present; high only in RESP.
- rsp_ready  in  1  initiator takes the response.
- rsp_rdata  out  64  load data, right-justified and zero-filled; 0 for stores and errors.
- rsp_err  out  1  request was misaligned or out of range.

## Operation
- States are IDLE, WAIT, ACCESS and RESP.
- **IDLE:** req_ready=1. On req_valid, capture addr, size, wdata and write.
  - On error, go to RESP with err=1.
  - Otherwise go to WAIT if WAIT_CYCLES>0, else to ACCESS.
- **Error conditions:**
  - half with addr[0]≠0;
  - word with addr[1:0]≠0;
  - double with addr[2:0]≠0;
  - addr ≥ DEPTH*8.
- **WAIT:** a counter loaded with WAIT_CYCLES decrements each cycle. When it reaches 1, go to ACCESS.
- **ACCESS** (one cycle):
  - Index is addr[3 +: log2(DEPTH)]; byte offset is addr[2:0].
  - Load: rdata = doubleword >> (8*offset), masked to 8/16/32/64 bits.
  - Store: enable the byte lanes offset .. offset+2^size-1. Replace those lanes with wdata bytes placed little-endian, and write the merged doubleword at the edge leaving ACCESS.
  - Next state is RESP.
- **RESP:** rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready, then return to IDLE. req_valid is ignored here.
- **Error responses:** never modify memory and return rdata=0.
- **Reset values:**
  - Reset forces IDLE, the counter to 0 and every captured field to 0.
  - Outputs after reset: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Array contents are not reset.
- **Reset mid-operation:** a reset in WAIT or ACCESS aborts the request with no memory write.

## Timing
- Acceptance edge: the rising edge where req_valid & req_ready.
- Valid access: WAIT occupies cycles 1..W and ACCESS occupies cycle W+1. rsp_valid is first high in cycle W+2, with W = WAIT_CYCLES.
- Error: rsp_valid is first high in cycle 1.
- Store commit: the write lands on the same edge that raises rsp_valid. A later request in the same or any subsequent access reads the new data.
- Throughput: with rsp_ready held high, a new request is accepted at best W+3 cycles after the previous acceptance, one request in flight.
- Outputs are registered from state or captured data; there is no combinational path from req_* to rsp_*.

## Structure
- Package mem_pkg holds:
  - the size encoding typedef (SZ_B, SZ_H, SZ_W, SZ_D);
  - the FSM state enum;
  - a function returning the byte mask for a size and offset.
- Sub-module mem_lane_align (combinational) performs both load extraction (shift + mask) and store merge (byte-enable select). The FSM, counter and array live in data_mem_responder.

## Test plan
- **Reset:** assert rst=0 mid-stream, then release → req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- **Double store/load, W=2:** store 0x1122334455667788 at 0x10, then double load at 0x10 → rsp_rdata=0x1122334455667788, rsp_valid first high in cycle 4 after acceptance.
- **Byte merge:** after the previous step, store 0xAB (wdata=0xFFFF_FFFF_FFFF_FFAB) at 0x13.
  - Double load at 0x10 → 0x11223344AB667788.
  - Byte load at 0x13 → 0x00000000000000AB.
  - Half load at 0x16 → 0x0000000000001122.
- **Error cases:**
  - Word load at 0x12 → rsp_err=1, rdata=0, in cycle 1.
  - Double store at DEPTH*8 → rsp_err=1, and the last doubleword is unchanged on readback.
- **Backpressure:** hold rsp_ready=0 for 5 cycles while req_valid toggles → rsp_valid, rsp_rdata and rsp_err stay constant, req_ready=0, and no second request is captured. Release → IDLE the next cycle.
- **Reset mid-WAIT:** with W=3, store 0xDEAD at 0x20 and pull rst low in WAIT cycle 2. After release, double load at 0x20 → the pre-existing value, not 0xDEAD.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder: access size encoding,
// responder FSM states and the byte-lane mask used for store merging.
package mem_pkg;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned LANES   = 8;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [LANES-1:0] byte_mask(input size_e sz, input logic [2:0] off);
    logic [LANES-1:0] base;
    case (sz)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a stored doubleword and the right-justified request data:
// load extraction (shift + size mask) and store merge (byte-enable select).
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [63:0] mem_dword,
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic [63:0] wdata,
  output logic [63:0] rdata_c,
  output logic [63:0] merged_c
);

  logic [63:0] shifted;
  logic [63:0] data_mask;
  logic [63:0] wshift;
  logic [7:0]  lane_en;

  always_comb begin
    shifted = mem_dword >> {offset, 3'b000};
    case (size_e'(size))
      SZ_B:    data_mask = 64'h0000_0000_0000_00FF;
      SZ_H:    data_mask = 64'h0000_0000_0000_FFFF;
      SZ_W:    data_mask = 64'h0000_0000_FFFF_FFFF;
      default: data_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    rdata_c = shifted & data_mask;

    wshift   = wdata << {offset, 3'b000};
    lane_en  = byte_mask(size_e'(size), offset);
    merged_c = mem_dword;
    for (int i = 0; i < 8; i++) begin
      if (lane_en[i]) merged_c[8*i +: 8] = wshift[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request in flight, WAIT_CYCLES wait states before the
// array access, byte-lane merged stores and right-justified zero-filled loads.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_INIT = CW'(WAIT_CYCLES);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW+2:0] addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          write_q, write_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [63:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic [63:0]   mem [DEPTH];
  logic [63:0]   mem_rd_c;
  logic [63:0]   ld_data_c;
  logic [63:0]   st_data_c;
  logic          mem_we_c;
  logic          misalign_c;
  logic          req_err_c;

  assign mem_rd_c = mem[addr_q[AW+2:3]];

  mem_lane_align u_align (
    .mem_dword (mem_rd_c),
    .offset    (addr_q[2:0]),
    .size      (size_q),
    .wdata     (wdata_q),
    .rdata_c   (ld_data_c),
    .merged_c  (st_data_c)
  );

  // Alignment and range check on the incoming request.
  always_comb begin
    case (size_e'(req_size))
      SZ_H:    misalign_c = req_addr[0];
      SZ_W:    misalign_c = |req_addr[1:0];
      SZ_D:    misalign_c = |req_addr[2:0];
      default: misalign_c = 1'b0;
    endcase
    req_err_c = misalign_c | (|req_addr[63:AW+3]);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr[AW+2:0];
          size_d  = req_size;
          wdata_d = req_wdata;
          write_d = req_write;
          if (req_err_c) begin
            state_d     = ST_RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_d     = ST_RESP;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = write_q ? 64'd0 : ld_data_c;
        mem_we_c    = write_q;
      end
      default: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array is not reset; a reset in WAIT/ACCESS leaves state_q out of ACCESS so no write fires.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[addr_q[AW+2:3]] <= st_data_c;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder against a byte-array memory model;
// two instances cover WAIT_CYCLES=2 (DEPTH=32) and WAIT_CYCLES=3 (DEPTH=16).
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [63:0] req_addr  [2];
  logic [1:0]  req_size  [2];
  logic [63:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [63:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int total = 0;
  int bad   = 0;

  int depth_of [2] = '{32, 16};
  int wait_of  [2] = '{2, 3};
  logic [7:0] mb [2][256];

  data_mem_responder #(.DEPTH(32), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_responder #(.DEPTH(16), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: memory as a flat byte array, little-endian.
  function automatic bit m_err(input int d, input logic [63:0] a, input logic [1:0] sz);
    logic [63:0] n;
    n = 64'(1 << sz);
    return ((a % n) != 64'd0) || (a >= 64'(depth_of[d] * 8));
  endfunction

  function automatic logic [63:0] m_load(input int d, input logic [63:0] a, input logic [1:0] sz);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < (1 << sz); i++) r[8*i +: 8] = mb[d][int'(a[15:0]) + i];
    return r;
  endfunction

  task automatic m_store(input int d, input logic [63:0] a, input logic [1:0] sz, input logic [63:0] wd);
    for (int i = 0; i < (1 << sz); i++) mb[d][int'(a[15:0]) + i] = wd[8*i +: 8];
  endtask

  task automatic check_idle_outputs(input int d, input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready[d]), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid[d]), 64'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata[d], 64'd0);
    chk({tag, "_rsp_err"},   64'(rsp_err[d]),   64'd0);
  endtask

  // Drive one request (called #1 after an edge); returns response and cycles from acceptance.
  task automatic xact(input int d, input bit wr, input logic [63:0] a, input logic [1:0] sz,
                      input logic [63:0] wd, output logic [63:0] rd, output logic er, output int lat);
    bit acc;
    acc = 1'b0;
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = a; req_size[d] = sz; req_wdata[d] = wd;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (req_ready[d]) acc = 1'b1;
      @(posedge clk); #1;
    end
    req_valid[d] = 1'b0;
    chk("accepted", 64'(acc), 64'd1);
    lat = 0;
    for (int k = 1; k <= 64; k++) begin
      if (rsp_valid[d]) begin lat = k; break; end
      @(posedge clk); #1;
    end
    rd = rsp_rdata[d];
    er = rsp_err[d];
    @(posedge clk); #1;
  endtask

  task automatic run(input int d, input bit wr, input logic [63:0] a, input logic [1:0] sz,
                     input logic [63:0] wd, input string tag, output logic [63:0] rd);
    logic        e, er;
    logic [63:0] exp_rd;
    int          lat, exp_lat;
    e       = m_err(d, a, sz);
    exp_rd  = (wr || e) ? 64'd0 : m_load(d, a, sz);
    exp_lat = e ? 1 : wait_of[d] + 2;
    xact(d, wr, a, sz, wd, rd, er, lat);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 64'(er), 64'(e));
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    if (wr && !e) m_store(d, a, sz, wd);
  endtask

  // Accept a request and stop #1 into cycle `cyc` after acceptance, then pulse reset.
  task automatic abort_with_reset(input int d, input logic [63:0] a, input logic [63:0] wd,
                                  input int cyc, input string tag);
    req_valid[d] = 1'b1; req_write[d] = 1'b1; req_addr[d] = a; req_size[d] = 2'd3; req_wdata[d] = wd;
    chk({tag, "_ready"}, 64'(req_ready[d]), 64'd1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    for (int i = 1; i < cyc; i++) begin @(posedge clk); #1; end
    chk({tag, "_busy"}, 64'(req_ready[d]), 64'd0);
    rst_n[d] = 1'b0;
    #1;
    check_idle_outputs(d, tag);
    @(posedge clk); #1;
    rst_n[d] = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] rd, a, wd, hold_exp;
    logic [1:0]  sz;
    bit          wr;
    int          r;

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
      req_size[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) rst_n[d] = 1'b1;
    check_idle_outputs(0, "reset0");
    check_idle_outputs(1, "reset1");

    // Fill both memories so every model byte is known.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < depth_of[d]; i++)
        run(d, 1'b1, 64'(i * 8), 2'd3, {$urandom, $urandom}, "fill", rd);

    // Directed: double store/load, byte merge, sub-word loads.
    run(0, 1'b1, 64'h10, 2'd3, 64'h1122334455667788, "dst", rd);
    run(0, 1'b0, 64'h10, 2'd3, 64'd0, "dld", rd);
    chk("dld_const", rd, 64'h1122334455667788);
    run(0, 1'b1, 64'h13, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB, "bst", rd);
    run(0, 1'b0, 64'h10, 2'd3, 64'd0, "merge", rd);
    chk("merge_const", rd, 64'h11223344AB667788);
    run(0, 1'b0, 64'h13, 2'd0, 64'd0, "bld", rd);
    chk("bld_const", rd, 64'h0000_0000_0000_00AB);
    run(0, 1'b0, 64'h16, 2'd1, 64'd0, "hld", rd);
    chk("hld_const", rd, 64'h0000_0000_0000_1122);

    // Errors: misaligned word load, out-of-range store leaves last doubleword intact.
    run(0, 1'b0, 64'h12, 2'd2, 64'd0, "err_mis", rd);
    run(0, 1'b1, 64'(32 * 8), 2'd3, 64'hCAFE_F00D_0BAD_BEEF, "err_oor", rd);
    run(0, 1'b0, 64'(31 * 8), 2'd3, 64'd0, "last_dw", rd);

    // Backpressure: response held while req_valid toggles.
    rsp_ready[0] = 1'b0;
    hold_exp = m_load(0, 64'h10, 2'd3);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 64'h10; req_size[0] = 2'd3;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    for (int k = 0; k < 20 && !rsp_valid[0]; k++) begin @(posedge clk); #1; end
    for (int i = 0; i < 5; i++) begin
      req_valid[0] = i[0]; req_write[0] = 1'b1; req_addr[0] = 64'h18; req_wdata[0] = 64'h5555;
      @(posedge clk); #1;
      chk("bp_valid", 64'(rsp_valid[0]), 64'd1);
      chk("bp_rdata", rsp_rdata[0], hold_exp);
      chk("bp_err",   64'(rsp_err[0]), 64'd0);
      chk("bp_ready", 64'(req_ready[0]), 64'd0);
    end
    req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_ready", 64'(req_ready[0]), 64'd1);
    chk("bp_rel_valid", 64'(rsp_valid[0]), 64'd0);
    run(0, 1'b0, 64'h18, 2'd3, 64'd0, "bp_nostore", rd);

    // Reset during ACCESS (cycle 3 for W=2) must drop the store.
    abort_with_reset(0, 64'h40, 64'h0000_0000_0000_DEAD, 3, "rst_acc");
    run(0, 1'b0, 64'h40, 2'd3, 64'd0, "rst_acc_rd", rd);

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < (d == 0 ? 200 : 80); n++) begin
        sz = 2'($urandom_range(0, 3));
        wr = 1'($urandom_range(0, 1));
        r  = $urandom_range(0, 9);
        a  = 64'($urandom_range(0, depth_of[d] * 8 - 1));
        if (r < 7) a = a & ~64'((1 << sz) - 1);
        else if (r == 9) a = {32'($urandom), 32'($urandom)} | 64'(depth_of[d] * 8);
        wd = {$urandom, $urandom};
        run(d, wr, a, sz, wd, "rand", rd);
      end
    end

    // Reset in WAIT cycle 2 with W=3 must drop the store.
    abort_with_reset(1, 64'h20, 64'h0000_0000_0000_DEAD, 2, "rst_wait");
    run(1, 1'b0, 64'h20, 2'd3, 64'd0, "rst_wait_rd", rd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
